// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with a single-block fill engine
// towards a 128-bit instruction memory, plus saturating hit/miss counters.
module icache_direct_mapped #(
    parameter int INDEX_BITS = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               read,
    input  logic [31:0]        address,
    input  logic               flush,
    output logic [31:0]        instruction,
    output logic               busywait,
    output logic               mem_read,
    output logic [27:0]        mem_address,
    input  logic [127:0]       mem_readdata,
    input  logic               mem_busywait,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MEM_READ = 2'b01,
        ST_UPDATE   = 2'b10
    } state_t;

    state_t                  state_r;
    logic [SETS-1:0]         valid_r;
    logic [127:0]            data_r [SETS];
    logic [TAG_W-1:0]        tag_r  [SETS];
    logic [TAG_W-1:0]        fill_tag_r;
    logic [INDEX_BITS-1:0]   fill_index_r;
    logic                    mem_read_r;
    logic [CNT_W-1:0]        hit_count_r;
    logic [CNT_W-1:0]        miss_count_r;

    logic [TAG_W-1:0]        req_tag_s;
    logic [INDEX_BITS-1:0]   req_index_s;
    logic [1:0]              word_sel_s;
    logic [127:0]            line_s;
    logic [31:0]             word_s;
    logic                    hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign req_tag_s   = address[31:4+INDEX_BITS];
    assign req_index_s = address[3+INDEX_BITS:4];
    assign word_sel_s  = address[3:2];
    assign line_s      = data_r[req_index_s];

    assign hit_s = read & valid_r[req_index_s] & (tag_r[req_index_s] == req_tag_s)
                 & (state_r == ST_IDLE) & ~flush;

    // Word selection within the addressed line
    always_comb begin
        word_s = 32'h0000_0000;
        case (word_sel_s)
            2'd0:    word_s = line_s[31:0];
            2'd1:    word_s = line_s[63:32];
            2'd2:    word_s = line_s[95:64];
            2'd3:    word_s = line_s[127:96];
            default: word_s = 32'h0000_0000;
        endcase
    end

    // CPU-facing outputs; busywait is forced low while reset is asserted
    always_comb begin
        instruction = 32'h0000_0000;
        busywait    = 1'b0;
        if (!reset) begin
            instruction = 32'h0000_0000;
            busywait    = 1'b0;
        end else begin
            instruction = hit_s ? word_s : 32'h0000_0000;
            busywait    = (read & ~hit_s) | (state_r != ST_IDLE);
        end
    end

    assign mem_read    = mem_read_r;
    assign mem_address = {fill_tag_r, fill_index_r};
    assign hit_count   = hit_count_r;
    assign miss_count  = miss_count_r;

    // Fill FSM, valid bits, fill address registers and performance counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            valid_r      <= '0;
            fill_tag_r   <= '0;
            fill_index_r <= '0;
            mem_read_r   <= 1'b0;
            hit_count_r  <= '0;
            miss_count_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        valid_r <= '0;
                    end else if (read && !hit_s) begin
                        fill_tag_r   <= req_tag_s;
                        fill_index_r <= req_index_s;
                        miss_count_r <= sat_inc(miss_count_r);
                        mem_read_r   <= 1'b1;
                        state_r      <= ST_MEM_READ;
                    end else if (hit_s) begin
                        hit_count_r <= sat_inc(hit_count_r);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MEM_READ: begin
                    if (!mem_busywait) begin
                        mem_read_r <= 1'b0;
                        state_r    <= ST_UPDATE;
                    end else begin
                        mem_read_r <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    valid_r[fill_index_r] <= 1'b1;
                    state_r               <= ST_IDLE;
                end
                default: begin
                    mem_read_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Line storage is never cleared; valid bits alone qualify its contents
    always_ff @(posedge clock) begin
        if (state_r == ST_UPDATE) begin
            data_r[fill_index_r] <= mem_readdata;
            tag_r[fill_index_r]  <= fill_tag_r;
        end
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: table of fetches plus hand-written
// sequences for flush, fill-address stability, counter saturation and reset mid-fill.
module tb_icache_direct_mapped;

    localparam int CNT_W  = 6;
    localparam int CNT_MX = 63;
    localparam int LAT    = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              read;
    logic [31:0]       address;
    logic              flush;
    logic [31:0]       instruction;
    logic              busywait;
    logic              mem_read;
    logic [27:0]       mem_address;
    logic [127:0]      mem_readdata;
    logic              mem_busywait;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int checks = 0;
    int errors = 0;
    int hit_m  = 0;
    int miss_m = 0;
    int mem_cnt;

    icache_direct_mapped #(.INDEX_BITS(3), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .read(read), .address(address), .flush(flush),
        .instruction(instruction), .busywait(busywait), .mem_read(mem_read),
        .mem_address(mem_address), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hc180_0013;
            32'h0000_0004: return 32'h0020_8093;
            32'h0000_0024: return 32'h0050_a103;
            default:       return 32'h1000_0000 | a;
        endcase
    endfunction

    assign mem_readdata = {mem_word({mem_address, 4'hc}), mem_word({mem_address, 4'h8}),
                           mem_word({mem_address, 4'h4}), mem_word({mem_address, 4'h0})};
    assign mem_busywait = !(mem_read && mem_cnt == LAT - 1);

    // Instruction memory latency counter, wraps when a block completes
    always @(posedge clock or negedge reset) begin
        if (!reset)                                mem_cnt <= 0;
        else if (mem_read && mem_cnt == LAT - 1)   mem_cnt <= 0;
        else if (mem_read)                         mem_cnt <= mem_cnt + 1;
        else                                       mem_cnt <= 0;
    end

    function automatic int sat(input int v);
        return (v >= CNT_MX) ? CNT_MX : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string name);
        chk({name, " hit_count"}, 32'(hit_count), 32'(hit_m));
        chk({name, " miss_count"}, 32'(miss_count), 32'(miss_m));
    endtask

    task automatic fetch(input logic [31:0] addr, input logic exp_miss, input logic [31:0] exp_instr);
        int stall;
        @(negedge clock);
        read = 1'b1;
        address = addr;
        #1;
        stall = 0;
        while (busywait === 1'b1 && stall < 100) begin
            if (stall == 1) begin
                chk("fill mem_read", 32'(mem_read), 32'd1);
                chk("fill mem_address", 32'(mem_address), 32'(addr[31:4]));
            end
            stall++;
            @(negedge clock);
            #1;
        end
        chk("stall cycles", 32'(stall), exp_miss ? 32'(LAT + 2) : 32'd0);
        chk("instruction", instruction, exp_instr);
        if (!exp_miss) chk("hit mem_read", 32'(mem_read), 32'd0);
        if (exp_miss) miss_m = sat(miss_m);
        hit_m = sat(hit_m);
        @(negedge clock);
        read = 1'b0;
        #1;
        chk("idle busywait", 32'(busywait), 32'd0);
        chk("idle instruction", instruction, 32'd0);
        chk_counters("after fetch");
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        flush_first;
        logic        exp_miss;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int g;
        int k;
        vecs[0] = '{32'h0000_0000, 1'b0, 1'b1, 32'hc180_0013};
        vecs[1] = '{32'h0000_0004, 1'b0, 1'b0, 32'h0020_8093};
        vecs[2] = '{32'h0000_0024, 1'b0, 1'b1, 32'h0050_a103};
        vecs[3] = '{32'h0000_0080, 1'b0, 1'b1, 32'h1000_0080};
        vecs[4] = '{32'h0000_0000, 1'b0, 1'b1, 32'hc180_0013};
        vecs[5] = '{32'h0000_0028, 1'b0, 1'b0, 32'h1000_0028};
        vecs[6] = '{32'h0000_0004, 1'b1, 1'b1, 32'h0020_8093};
        vecs[7] = '{32'h0000_0084, 1'b0, 1'b1, 32'h1000_0084};

        reset = 1'b0;
        read = 1'b1;
        address = 32'h0000_0000;
        flush = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("reset busywait", 32'(busywait), 32'd0);
        chk("reset instruction", instruction, 32'd0);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset mem_address", 32'(mem_address), 32'd0);
        chk_counters("reset");
        read = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].flush_first) begin
                @(negedge clock);
                flush = 1'b1;
                #1;
                chk("flush busywait", 32'(busywait), 32'd0);
                @(negedge clock);
                flush = 1'b0;
            end
            fetch(vecs[i].addr, vecs[i].exp_miss, vecs[i].exp_instr);
        end

        // flush and read together in IDLE: flush wins, no fill, no counting
        @(negedge clock);
        read = 1'b1;
        address = 32'h0000_0084;
        flush = 1'b1;
        #1;
        chk("flush+read busywait", 32'(busywait), 32'd1);
        chk("flush+read instruction", instruction, 32'd0);
        @(negedge clock);
        #1;
        chk("flush+read mem_read", 32'(mem_read), 32'd0);
        chk_counters("flush+read");
        flush = 1'b0;
        read = 1'b0;
        fetch(32'h0000_0084, 1'b1, 32'h1000_0084);

        // flush and address change while filling do not disturb the fill
        @(negedge clock);
        read = 1'b1;
        address = 32'h0000_0024;
        #1;
        chk("miss busywait", 32'(busywait), 32'd1);
        @(negedge clock);
        flush = 1'b1;
        address = 32'h0000_0080;
        #1;
        chk("mid-fill mem_read", 32'(mem_read), 32'd1);
        chk("mid-fill mem_address", 32'(mem_address), 32'h0000_0002);
        @(negedge clock);
        flush = 1'b0;
        address = 32'h0000_0024;
        g = 0;
        while (busywait === 1'b1 && g < 50) begin
            g++;
            @(negedge clock);
            #1;
        end
        chk("fill-flush done", 32'(g < 50), 32'd1);
        chk("fill-flush instruction", instruction, 32'h0050_a103);
        miss_m = sat(miss_m);
        hit_m = sat(hit_m);
        @(negedge clock);
        read = 1'b0;
        fetch(32'h0000_0024, 1'b0, 32'h0050_a103);

        // hold a hitting read long enough to saturate the hit counter
        @(negedge clock);
        read = 1'b1;
        address = 32'h0000_0024;
        for (int i = 0; i < 70; i++) begin
            @(negedge clock);
            hit_m = sat(hit_m);
        end
        read = 1'b0;
        #1;
        chk("saturated hit_count", 32'(hit_count), 32'(CNT_MX));
        chk_counters("saturation");

        // asynchronous reset during the fifth MEM_READ cycle
        @(negedge clock);
        read = 1'b1;
        address = 32'h0000_0000;
        #1;
        k = 0;
        g = 0;
        while (k < 5 && g < 50) begin
            g++;
            @(negedge clock);
            #1;
            if (mem_read) k++;
        end
        chk("reached MEM_READ cycle 5", 32'(k), 32'd5);
        reset = 1'b0;
        #1;
        chk("mid-fill reset mem_read", 32'(mem_read), 32'd0);
        chk("mid-fill reset busywait", 32'(busywait), 32'd0);
        chk("mid-fill reset mem_address", 32'(mem_address), 32'd0);
        hit_m = 0;
        miss_m = 0;
        chk_counters("mid-fill reset");
        @(negedge clock);
        read = 1'b0;
        reset = 1'b1;
        fetch(32'h0000_0000, 1'b1, 32'hc180_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
